l2tlb_cam: RTL and testbench
============================

# l2tlb_cam

Parametrised L2 TLB instantiated inside the l2cache, in place of the identity-passthrough L2 TLB. It serves l1TLB translation requests from a fully associative table of `ENTRIES` translations tagged by context slot. It tracks up to `SLOTS` SPTBR contexts and accepts refills. When it evicts an entry or a whole context, it snoops the l1TLB to invalidate the stale translation.

## Interface
- `ENTRIES`, 16: translation entries, power of two, 2..64.
- `SLOTS`, 4: tracked SPTBR contexts, power of two, 2..8.
- `RID_W`, 5: request id width.
- `VPN_W`, 27: virtual page number width (`laddr[38:12]`).
- `SPTBR_W`, 38: context pointer width.
- `HPADDR_W`, 11: hashed physical page width. `ppaddr` is `hpaddr[2:0]`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1, `req_retry` out 1: l1TLB lookup request handshake.
- `req_rid` in `RID_W`, `req_vpn` in `VPN_W`, `req_sptbr` in `SPTBR_W`: request payload.
- `fill_valid` in 1, `fill_retry` out 1: refill handshake.
- `fill_vpn` in `VPN_W`, `fill_sptbr` in `SPTBR_W`, `fill_hpaddr` in `HPADDR_W`: refill payload.
- `ack_valid` out 1, `ack_retry` in 1: response to the l1TLB.
- `ack_rid` out `RID_W`, `ack_hpaddr` out `HPADDR_W`, `ack_ppaddr` out 3, `ack_fault` out 1: response payload.
- `snoop_valid` out 1, `snoop_retry` in 1: l1TLB invalidate.
- `snoop_ctx` out 1: 1 means drop all translations of `snoop_sptbr`; 0 means drop `snoop_hpaddr`.
- `snoop_sptbr` out `SPTBR_W`, `snoop_hpaddr` out `HPADDR_W`: snoop payload.

## Operation
- Handshake: a transfer occurs in a cycle with valid=1 and retry=0. A sender holds valid and payload stable while retry=1.
- Slot table:
  - Each of the `SLOTS` entries is `{valid, sptbr}`.
  - Each translation entry is `{valid, slot, vpn, hpaddr}`.
- Request, context lookup:
  - `req_sptbr` is matched against the valid slots.
  - If no slot matches, the block allocates the lowest free slot.
  - If no slot is free, it evicts the slot at `slot_ptr`:
    - All entries with that slot are cleared at the same edge.
    - A snoop with `snoop_ctx=1` is issued carrying the old sptbr.
    - `slot_ptr` increments modulo `SLOTS`.
    - The request is then a guaranteed miss.
- Request, translation lookup: a hit requires valid, slot equal, and vpn equal. On a hit, the ack carries hpaddr with fault=0. On a miss, see Configuration.
- Fill, slot match:
  - If `fill_sptbr` matches no valid slot, the fill is accepted and discarded.
- Fill, entry selection, in priority order:
  1. An existing {slot, vpn} match, which is overwritten with no snoop.
  2. The lowest invalid entry.
  3. Otherwise the victim at `ent_ptr`, which increments modulo `ENTRIES`. The victim's hpaddr is snooped with `snoop_ctx=0`.
- Snoop register: one register, state `SNP_IDLE`/`SNP_BUSY`.
  - `SNP_BUSY` is entered when a snoop is generated.
  - It returns to `SNP_IDLE` when the snoop transfers.
  - At most one snoop is generated per cycle. A context eviction and an entry eviction are mutually exclusive (see retry rules).
- `req_retry` = (`ack_valid` & `ack_retry`) | `SNP_BUSY`.
- `fill_retry` = `SNP_BUSY` | (`req_valid` & ~`req_retry` & request needs a context eviction).
- Simultaneous request and fill:
  - Both are accepted.
  - The lookup sees the table contents before the edge, so a fill of the same vpn does not hit this cycle.

## Timing
- Reset:
  - All valid outputs are 0 and all payload outputs are 0.
  - All entries and slots are invalid.
  - `slot_ptr`, `ent_ptr` are 0. The snoop FSM is in `SNP_IDLE`.
  - Reset asserted mid-operation discards any pending ack or snoop the next cycle.
- Lookup latency: a request accepted at edge N gives `ack_valid`=1 after edge N. Throughput is one request per cycle while `ack_retry`=0.
- Fill write takes effect at the accepting edge. A request in the following cycle hits.
- A snoop appears in the cycle after the causing transfer. Requests and fills stall until it transfers.
- Pointer wrap: at `ENTRIES-1` the pointer goes to 0, and at `SLOTS-1` the pointer goes to 0.

## Configuration
- `L2TLB_IDENTITY_MISS_EN` defined: a miss returns an identity translation with `ack_hpaddr=req_vpn[HPADDR_W-1:0]` and `ack_fault=0`. This keeps bring-up compatible with the passthrough behaviour.
- `L2TLB_IDENTITY_MISS_EN` undefined: a miss returns `ack_hpaddr=0`, `ack_fault=1`.

## Structure
- Shared package `l2tlb_pkg`:
  - Entry struct, slot struct, ack struct, snoop struct.
  - `SNP_IDLE`/`SNP_BUSY` enum.
  - `PPADDR_W=3`.
- Output registers use the existing `fflop` for the ack and snoop channels.
- One sub-module: `l2tlb_cam_match`. It takes the entry array, slot, and vpn, and returns a one-hot hit vector, the first-invalid index, and a hit flag. It is used for both the request and fill paths.

## Test plan
- After reset, request rid=3, vpn=0x1234, sptbr=0xA:
  - Undefined macro → ack rid=3, fault=1 one cycle later.
  - Defined macro → hpaddr=0x234, fault=0.
- Fill sptbr=0xA, vpn=0x1234, hpaddr=0x5A1, then request the same → ack hpaddr=0x5A1, ppaddr=1, fault=0. Hold `ack_retry`=1 for 3 cycles → ack stable, `req_retry`=1.
- Fill 17 distinct vpns into one context with `ENTRIES`=16 → the 17th fill snoops `snoop_ctx=0` with entry 0's hpaddr. Looking up the first vpn misses.
- Requests with 5 distinct sptbrs, `SLOTS`=4 → the 5th request issues snoop `snoop_ctx=1` with sptbr of slot 0. Prior translations of that context miss.
- Hold `snoop_retry`=1 for 4 cycles → `req_retry`=`fill_retry`=1 throughout; the snoop payload is stable.
- Fill and request of the same vpn in the same cycle → miss. Request the next cycle → hit.

Source files
------------

// File: rtl/l2tlb_pkg.sv
// Shared types for the L2 TLB CAM: table entries, context slots, ack/snoop payloads
// and the snoop register state.
package l2tlb_pkg;

  localparam int L2TLB_RID_W    = 5;
  localparam int L2TLB_VPN_W    = 27;
  localparam int L2TLB_SPTBR_W  = 38;
  localparam int L2TLB_HPADDR_W = 11;
  localparam int PPADDR_W       = 3;
  // Slot tags are stored at the widest supported size (up to 8 contexts).
  localparam int L2TLB_SLOT_W   = 3;

  typedef enum logic {
    SNP_IDLE = 1'b0,
    SNP_BUSY = 1'b1
  } snp_state_e;

  typedef struct packed {
    logic                      valid;
    logic [L2TLB_SLOT_W-1:0]   slot;
    logic [L2TLB_VPN_W-1:0]    vpn;
    logic [L2TLB_HPADDR_W-1:0] hpaddr;
  } entry_t;

  typedef struct packed {
    logic                     valid;
    logic [L2TLB_SPTBR_W-1:0] sptbr;
  } slot_t;

  typedef struct packed {
    logic [L2TLB_RID_W-1:0]    rid;
    logic [L2TLB_HPADDR_W-1:0] hpaddr;
    logic [PPADDR_W-1:0]       ppaddr;
    logic                      fault;
  } ack_t;

  typedef struct packed {
    logic                      ctx;
    logic [L2TLB_SPTBR_W-1:0]  sptbr;
    logic [L2TLB_HPADDR_W-1:0] hpaddr;
  } snoop_t;

  function automatic logic [PPADDR_W-1:0] ppaddr_of(input logic [L2TLB_HPADDR_W-1:0] hp);
    return hp[PPADDR_W-1:0];
  endfunction

endpackage

// File: rtl/l2tlb_cam_if.sv
// l1TLB <-> L2 TLB channels. Every channel is valid/retry: a beat moves in a cycle with
// valid=1 and retry=0, and the sender holds valid and payload stable while retry=1.
interface l2tlb_cam_if #(
  parameter int RID_W    = 5,
  parameter int VPN_W    = 27,
  parameter int SPTBR_W  = 38,
  parameter int HPADDR_W = 11
);
  logic                req_valid;
  logic                req_retry;
  logic [RID_W-1:0]    req_rid;
  logic [VPN_W-1:0]    req_vpn;
  logic [SPTBR_W-1:0]  req_sptbr;

  logic                fill_valid;
  logic                fill_retry;
  logic [VPN_W-1:0]    fill_vpn;
  logic [SPTBR_W-1:0]  fill_sptbr;
  logic [HPADDR_W-1:0] fill_hpaddr;

  logic                ack_valid;
  logic                ack_retry;
  logic [RID_W-1:0]    ack_rid;
  logic [HPADDR_W-1:0] ack_hpaddr;
  logic [2:0]          ack_ppaddr;
  logic                ack_fault;

  logic                snoop_valid;
  logic                snoop_retry;
  logic                snoop_ctx;
  logic [SPTBR_W-1:0]  snoop_sptbr;
  logic [HPADDR_W-1:0] snoop_hpaddr;

  modport master (
    output req_valid, req_rid, req_vpn, req_sptbr,
    output fill_valid, fill_vpn, fill_sptbr, fill_hpaddr,
    output ack_retry, snoop_retry,
    input  req_retry, fill_retry,
    input  ack_valid, ack_rid, ack_hpaddr, ack_ppaddr, ack_fault,
    input  snoop_valid, snoop_ctx, snoop_sptbr, snoop_hpaddr
  );

  modport slave (
    input  req_valid, req_rid, req_vpn, req_sptbr,
    input  fill_valid, fill_vpn, fill_sptbr, fill_hpaddr,
    input  ack_retry, snoop_retry,
    output req_retry, fill_retry,
    output ack_valid, ack_rid, ack_hpaddr, ack_ppaddr, ack_fault,
    output snoop_valid, snoop_ctx, snoop_sptbr, snoop_hpaddr
  );
endinterface

// File: rtl/fflop.sv
// Single-stage valid/retry output register. Holds its beat while the consumer retries;
// the upstream retry is therefore valid_q & q_retry. Clears valid and data on reset.
module fflop #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         din_valid,
  output logic         din_retry,
  input  logic [W-1:0] din,
  output logic         q_valid,
  input  logic         q_retry,
  output logic [W-1:0] q
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign din_retry = valid_q & q_retry;
  assign q_valid   = valid_q;
  assign q         = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!din_retry) begin
      valid_d = din_valid;
      if (din_valid) data_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/l2tlb_cam_match.sv
// Fully associative compare of {slot, vpn} against the entry table. Returns the one-hot
// hit vector, a hit flag and the lowest invalid entry index.
module l2tlb_cam_match
  import l2tlb_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  entry_t                       ents [ENTRIES],
  input  logic [L2TLB_SLOT_W-1:0]      slot,
  input  logic [L2TLB_VPN_W-1:0]       vpn,
  output logic [ENTRIES-1:0]           hit_vec,
  output logic                         hit,
  output logic                         inv_any,
  output logic [$clog2(ENTRIES)-1:0]   inv_idx
);
  localparam int IDX_W = $clog2(ENTRIES);

  // Descending scan so the last assignment leaves the lowest invalid index.
  always_comb begin
    hit_vec = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      hit_vec[e] = ents[e].valid && (ents[e].slot == slot) && (ents[e].vpn == vpn);
      if (!ents[e].valid) begin
        inv_any = 1'b1;
        inv_idx = IDX_W'(e);
      end
    end
  end

  assign hit = |hit_vec;
endmodule

// File: rtl/l2tlb_cam.sv
// L2 TLB: fully associative translation table tagged by SPTBR context slot, with refill
// and l1TLB snoop on eviction. Define L2TLB_IDENTITY_MISS_EN to answer misses with an identity map.
module l2tlb_cam
  import l2tlb_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int SLOTS    = 4,
  parameter int RID_W    = L2TLB_RID_W,
  parameter int VPN_W    = L2TLB_VPN_W,
  parameter int SPTBR_W  = L2TLB_SPTBR_W,
  parameter int HPADDR_W = L2TLB_HPADDR_W
) (
  input  logic       clk,
  input  logic       reset,
  l2tlb_cam_if.slave bus,
  output snp_state_e dbg_snp_state
);
  localparam int EIDX_W = $clog2(ENTRIES);
  localparam int SIDX_W = $clog2(SLOTS);

  logic [RID_W-1:0]    req_rid;
  logic [VPN_W-1:0]    req_vpn, fill_vpn;
  logic [SPTBR_W-1:0]  req_sptbr, fill_sptbr;
  logic [HPADDR_W-1:0] fill_hpaddr;

  assign req_rid     = bus.req_rid;
  assign req_vpn     = bus.req_vpn;
  assign req_sptbr   = bus.req_sptbr;
  assign fill_vpn    = bus.fill_vpn;
  assign fill_sptbr  = bus.fill_sptbr;
  assign fill_hpaddr = bus.fill_hpaddr;

  entry_t             ent_q  [ENTRIES];
  entry_t             ent_d  [ENTRIES];
  slot_t              slot_q [SLOTS];
  slot_t              slot_d [SLOTS];
  logic [SIDX_W-1:0]  slot_ptr_q, slot_ptr_d;
  logic [EIDX_W-1:0]  ent_ptr_q, ent_ptr_d;
  snp_state_e         snp_state_q, snp_state_d;

  // Context lookup for both request and fill paths.
  logic              req_slot_hit, fill_slot_hit, free_any;
  logic [SIDX_W-1:0] req_slot_idx, fill_slot_idx, free_idx, req_slot_sel;
  logic              req_ctx_evict;

  always_comb begin
    req_slot_hit  = 1'b0;
    req_slot_idx  = '0;
    fill_slot_hit = 1'b0;
    fill_slot_idx = '0;
    free_any      = 1'b0;
    free_idx      = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (slot_q[s].valid && (slot_q[s].sptbr == req_sptbr)) begin
        req_slot_hit = 1'b1;
        req_slot_idx = SIDX_W'(s);
      end
      if (slot_q[s].valid && (slot_q[s].sptbr == fill_sptbr)) begin
        fill_slot_hit = 1'b1;
        fill_slot_idx = SIDX_W'(s);
      end
      if (!slot_q[s].valid) begin
        free_any = 1'b1;
        free_idx = SIDX_W'(s);
      end
    end
    req_ctx_evict = !req_slot_hit && !free_any;
    req_slot_sel  = req_slot_hit ? req_slot_idx : (free_any ? free_idx : slot_ptr_q);
  end

  logic [ENTRIES-1:0] req_hit_vec, fill_hit_vec;
  logic               req_ent_hit, fill_ent_hit, fill_inv_any;
  logic [EIDX_W-1:0]  fill_inv_idx;
  logic               unused_req_inv_any;
  logic [EIDX_W-1:0]  unused_req_inv_idx;

  l2tlb_cam_match #(.ENTRIES(ENTRIES)) u_req_match (
    .ents    (ent_q),
    .slot    (L2TLB_SLOT_W'(req_slot_idx)),
    .vpn     (req_vpn),
    .hit_vec (req_hit_vec),
    .hit     (req_ent_hit),
    .inv_any (unused_req_inv_any),
    .inv_idx (unused_req_inv_idx)
  );

  l2tlb_cam_match #(.ENTRIES(ENTRIES)) u_fill_match (
    .ents    (ent_q),
    .slot    (L2TLB_SLOT_W'(fill_slot_idx)),
    .vpn     (fill_vpn),
    .hit_vec (fill_hit_vec),
    .hit     (fill_ent_hit),
    .inv_any (fill_inv_any),
    .inv_idx (fill_inv_idx)
  );

  // Handshake control.
  logic ack_in_retry, snp_busy;
  logic req_fire, fill_fire, fill_do, fill_evict, ctx_evict;

  assign snp_busy       = (snp_state_q == SNP_BUSY);
  assign bus.req_retry  = ack_in_retry | snp_busy;
  assign bus.fill_retry = snp_busy | (bus.req_valid & ~bus.req_retry & req_ctx_evict);
  assign req_fire       = bus.req_valid & ~bus.req_retry;
  assign fill_fire      = bus.fill_valid & ~bus.fill_retry;
  assign ctx_evict      = req_fire & req_ctx_evict;
  // Fills for an untracked context are consumed without touching the table.
  assign fill_do        = fill_fire & fill_slot_hit;
  assign fill_evict     = fill_do & ~fill_ent_hit & ~fill_inv_any;

  // Request hit data; the hit vector is at most one-hot.
  logic                req_lookup_hit;
  logic [HPADDR_W-1:0] req_hit_hpaddr;

  always_comb begin
    req_hit_hpaddr = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (req_hit_vec[e]) req_hit_hpaddr = req_hit_hpaddr | ent_q[e].hpaddr;
    end
    req_lookup_hit = req_slot_hit & req_ent_hit;
  end

  // Table and pointer updates. Context eviction and fill never share a cycle.
  logic [EIDX_W-1:0]  fill_sel_idx;
  logic [ENTRIES-1:0] fill_we;

  always_comb begin
    fill_sel_idx = fill_inv_any ? fill_inv_idx : ent_ptr_q;
    for (int e = 0; e < ENTRIES; e++) begin
      fill_we[e] = fill_ent_hit ? fill_hit_vec[e] : (EIDX_W'(e) == fill_sel_idx);
    end
  end

  always_comb begin
    for (int e = 0; e < ENTRIES; e++) ent_d[e] = ent_q[e];
    for (int s = 0; s < SLOTS; s++) slot_d[s] = slot_q[s];
    slot_ptr_d = slot_ptr_q;
    ent_ptr_d  = ent_ptr_q;

    if (req_fire && !req_slot_hit) begin
      slot_d[req_slot_sel].valid = 1'b1;
      slot_d[req_slot_sel].sptbr = req_sptbr;
    end
    if (ctx_evict) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (ent_q[e].slot == L2TLB_SLOT_W'(slot_ptr_q)) ent_d[e].valid = 1'b0;
      end
      slot_ptr_d = (slot_ptr_q == SIDX_W'(SLOTS - 1)) ? '0 : slot_ptr_q + 1'b1;
    end
    if (fill_do) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (fill_we[e]) begin
          ent_d[e].valid  = 1'b1;
          ent_d[e].slot   = L2TLB_SLOT_W'(fill_slot_idx);
          ent_d[e].vpn    = fill_vpn;
          ent_d[e].hpaddr = fill_hpaddr;
        end
      end
    end
    if (fill_evict) begin
      ent_ptr_d = (ent_ptr_q == EIDX_W'(ENTRIES - 1)) ? '0 : ent_ptr_q + 1'b1;
    end
  end

  // Ack payload.
  ack_t ack_in, ack_out;

  always_comb begin
    ack_in     = '0;
    ack_in.rid = req_rid;
    if (req_lookup_hit) begin
      ack_in.hpaddr = req_hit_hpaddr;
      ack_in.fault  = 1'b0;
    end else begin
`ifdef L2TLB_IDENTITY_MISS_EN
      ack_in.hpaddr = req_vpn[HPADDR_W-1:0];
      ack_in.fault  = 1'b0;
`else
      ack_in.hpaddr = '0;
      ack_in.fault  = 1'b1;
`endif
    end
    ack_in.ppaddr = ppaddr_of(ack_in.hpaddr);
  end

  fflop #(.W($bits(ack_t))) u_ack_ff (
    .clk       (clk),
    .reset     (reset),
    .din_valid (req_fire),
    .din_retry (ack_in_retry),
    .din       (ack_in),
    .q_valid   (bus.ack_valid),
    .q_retry   (bus.ack_retry),
    .q         (ack_out)
  );

  assign bus.ack_rid    = ack_out.rid;
  assign bus.ack_hpaddr = ack_out.hpaddr;
  assign bus.ack_ppaddr = ack_out.ppaddr;
  assign bus.ack_fault  = ack_out.fault;

  // Snoop generation and register.
  logic   snp_gen;
  logic   unused_snp_in_retry;
  snoop_t snp_in, snp_out;

  always_comb begin
    snp_gen = ctx_evict | fill_evict;
    snp_in  = '0;
    if (ctx_evict) begin
      snp_in.ctx   = 1'b1;
      snp_in.sptbr = slot_q[slot_ptr_q].sptbr;
    end else if (fill_evict) begin
      snp_in.ctx    = 1'b0;
      snp_in.hpaddr = ent_q[ent_ptr_q].hpaddr;
    end
  end

  always_comb begin
    snp_state_d = snp_state_q;
    case (snp_state_q)
      SNP_IDLE: if (snp_gen) snp_state_d = SNP_BUSY;
      SNP_BUSY: if (bus.snoop_valid && !bus.snoop_retry) snp_state_d = SNP_IDLE;
      default:  snp_state_d = SNP_IDLE;
    endcase
  end

  fflop #(.W($bits(snoop_t))) u_snoop_ff (
    .clk       (clk),
    .reset     (reset),
    .din_valid (snp_gen),
    .din_retry (unused_snp_in_retry),
    .din       (snp_in),
    .q_valid   (bus.snoop_valid),
    .q_retry   (bus.snoop_retry),
    .q         (snp_out)
  );

  assign bus.snoop_ctx    = snp_out.ctx;
  assign bus.snoop_sptbr  = snp_out.sptbr;
  assign bus.snoop_hpaddr = snp_out.hpaddr;
  assign dbg_snp_state    = snp_state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < ENTRIES; e++) ent_q[e] <= '0;
      for (int s = 0; s < SLOTS; s++) slot_q[s] <= '0;
      slot_ptr_q  <= '0;
      ent_ptr_q   <= '0;
      snp_state_q <= SNP_IDLE;
    end else begin
      for (int e = 0; e < ENTRIES; e++) ent_q[e] <= ent_d[e];
      for (int s = 0; s < SLOTS; s++) slot_q[s] <= slot_d[s];
      slot_ptr_q  <= slot_ptr_d;
      ent_ptr_q   <= ent_ptr_d;
      snp_state_q <= snp_state_d;
    end
  end
endmodule

// File: tb/tb_l2tlb_cam.sv
// Directed bench for l2tlb_cam (ENTRIES=16, SLOTS=4): miss/hit, ack backpressure, entry and
// context eviction snoops, snoop backpressure, same-cycle fill/request and mid-run reset.
module tb_l2tlb_cam;
  import l2tlb_pkg::*;

`ifdef L2TLB_IDENTITY_MISS_EN
  localparam bit IDENT = 1'b1;
`else
  localparam bit IDENT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  snp_state_e dbg_snp_state;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  l2tlb_cam_if bus ();

  l2tlb_cam #(.ENTRIES(16), .SLOTS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .dbg_snp_state (dbg_snp_state)
  );

  function automatic logic [10:0] miss_hp(input logic [26:0] vpn);
    return IDENT ? vpn[10:0] : 11'h0;
  endfunction

  // ---------------- clock/reset and drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0; bus.req_rid = '0; bus.req_vpn = '0; bus.req_sptbr = '0;
    bus.fill_valid = 1'b0; bus.fill_vpn = '0; bus.fill_sptbr = '0; bus.fill_hpaddr = '0;
    bus.ack_retry = 1'b0; bus.snoop_retry = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic send_req(input logic [4:0] rid, input logic [26:0] vpn, input logic [37:0] sptbr);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_rid = rid; bus.req_vpn = vpn; bus.req_sptbr = sptbr;
    #1;
    while (bus.req_retry && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    tests++;
    if (bus.req_retry !== 1'b0) begin fails++; $display("FAIL req_wait rid=%0d retry=%b required 0", rid, bus.req_retry); end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic send_fill(input logic [26:0] vpn, input logic [37:0] sptbr, input logic [10:0] hp);
    int n = 0;
    bus.fill_valid = 1'b1; bus.fill_vpn = vpn; bus.fill_sptbr = sptbr; bus.fill_hpaddr = hp;
    #1;
    while (bus.fill_retry && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    tests++;
    if (bus.fill_retry !== 1'b0) begin fails++; $display("FAIL fill_wait vpn=%0h retry=%b required 0", vpn, bus.fill_retry); end
    @(posedge clk);
    #1;
    bus.fill_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tests++; if (bus.ack_valid !== 1'b0) begin fails++; $display("FAIL rst_ack_valid got=%b exp=0", bus.ack_valid); end
    tests++; if (bus.snoop_valid !== 1'b0) begin fails++; $display("FAIL rst_snoop_valid got=%b exp=0", bus.snoop_valid); end
    tests++; if ({bus.ack_rid, bus.ack_hpaddr, bus.ack_ppaddr, bus.ack_fault} !== 20'h0) begin
      fails++; $display("FAIL rst_ack_payload got=%0h exp=0", {bus.ack_rid, bus.ack_hpaddr, bus.ack_ppaddr, bus.ack_fault}); end
    tests++; if ({bus.snoop_ctx, bus.snoop_sptbr, bus.snoop_hpaddr} !== 50'h0) begin
      fails++; $display("FAIL rst_snoop_payload got=%0h exp=0", {bus.snoop_ctx, bus.snoop_sptbr, bus.snoop_hpaddr}); end
    tests++; if ({bus.req_retry, bus.fill_retry} !== 2'b00) begin fails++; $display("FAIL rst_retry got=%b exp=00", {bus.req_retry, bus.fill_retry}); end
    tests++; if (dbg_snp_state !== SNP_IDLE) begin fails++; $display("FAIL rst_snp_state got=%0d exp=%0d", dbg_snp_state, SNP_IDLE); end
  endtask

  task automatic test_miss();
    logic [10:0] exp_hp;
    exp_hp = miss_hp(27'h1234);
    send_req(5'd3, 27'h1234, 38'hA);
    tests++; if (bus.ack_valid !== 1'b1) begin fails++; $display("FAIL miss_ack_valid got=%b exp=1", bus.ack_valid); end
    tests++; if (bus.ack_rid !== 5'd3) begin fails++; $display("FAIL miss_rid got=%0d exp=3", bus.ack_rid); end
    tests++; if (bus.ack_fault !== !IDENT) begin fails++; $display("FAIL miss_fault got=%b exp=%b", bus.ack_fault, !IDENT); end
    tests++; if (bus.ack_hpaddr !== exp_hp) begin fails++; $display("FAIL miss_hpaddr got=%0h exp=%0h", bus.ack_hpaddr, exp_hp); end
    tests++; if (bus.ack_ppaddr !== exp_hp[2:0]) begin fails++; $display("FAIL miss_ppaddr got=%0h exp=%0h", bus.ack_ppaddr, exp_hp[2:0]); end
    step();
    tests++; if (bus.ack_valid !== 1'b0) begin fails++; $display("FAIL miss_ack_drop got=%b exp=0", bus.ack_valid); end
  endtask

  task automatic test_fill_hit();
    send_fill(27'h1234, 38'hA, 11'h5A1);
    send_req(5'd7, 27'h1234, 38'hA);
    tests++; if ({bus.ack_valid, bus.ack_rid, bus.ack_hpaddr, bus.ack_ppaddr, bus.ack_fault} !== {1'b1, 5'd7, 11'h5A1, 3'd1, 1'b0}) begin
      fails++; $display("FAIL hit_ack got v=%b rid=%0d hp=%0h pp=%0d f=%b exp v=1 rid=7 hp=5a1 pp=1 f=0",
                        bus.ack_valid, bus.ack_rid, bus.ack_hpaddr, bus.ack_ppaddr, bus.ack_fault); end
    bus.ack_retry = 1'b1;
    bus.req_valid = 1'b1; bus.req_rid = 5'd8; bus.req_vpn = 27'h1234; bus.req_sptbr = 38'hA;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++; if ({bus.req_retry, bus.ack_valid, bus.ack_rid, bus.ack_hpaddr} !== {1'b1, 1'b1, 5'd7, 11'h5A1}) begin
        fails++; $display("FAIL ack_hold[%0d] got rr=%b v=%b rid=%0d hp=%0h exp rr=1 v=1 rid=7 hp=5a1",
                          k, bus.req_retry, bus.ack_valid, bus.ack_rid, bus.ack_hpaddr); end
      step();
    end
    bus.ack_retry = 1'b0;
    #1;
    tests++; if (bus.req_retry !== 1'b0) begin fails++; $display("FAIL ack_release_retry got=%b exp=0", bus.req_retry); end
    step();
    bus.req_valid = 1'b0;
    tests++; if ({bus.ack_valid, bus.ack_rid, bus.ack_hpaddr} !== {1'b1, 5'd8, 11'h5A1}) begin
      fails++; $display("FAIL ack_next got v=%b rid=%0d hp=%0h exp v=1 rid=8 hp=5a1", bus.ack_valid, bus.ack_rid, bus.ack_hpaddr); end
    step();
  endtask

  task automatic test_entry_evict();
    logic [10:0] exp_hp;
    do_reset();
    send_req(5'd1, 27'h999, 38'hB);
    for (int i = 0; i < 16; i++) send_fill(27'h100 + 27'(i), 38'hB, 11'h400 + 11'(i));
    tests++; if (bus.snoop_valid !== 1'b0) begin fails++; $display("FAIL ent_no_snoop got=%b exp=0", bus.snoop_valid); end
    send_fill(27'h200, 38'hB, 11'h7FF);
    tests++; if ({bus.snoop_valid, bus.snoop_ctx, bus.snoop_hpaddr} !== {1'b1, 1'b0, 11'h400}) begin
      fails++; $display("FAIL ent_snoop got v=%b ctx=%b hp=%0h exp v=1 ctx=0 hp=400", bus.snoop_valid, bus.snoop_ctx, bus.snoop_hpaddr); end
    tests++; if ({bus.fill_retry, dbg_snp_state} !== {1'b1, SNP_BUSY}) begin
      fails++; $display("FAIL ent_busy got fr=%b st=%0d exp fr=1 st=1", bus.fill_retry, dbg_snp_state); end
    step();
    tests++; if (bus.snoop_valid !== 1'b0) begin fails++; $display("FAIL ent_snoop_done got=%b exp=0", bus.snoop_valid); end
    exp_hp = miss_hp(27'h100);
    send_req(5'd2, 27'h100, 38'hB);
    tests++; if ({bus.ack_hpaddr, bus.ack_fault} !== {exp_hp, !IDENT}) begin
      fails++; $display("FAIL ent_victim_miss got hp=%0h f=%b exp hp=%0h f=%b", bus.ack_hpaddr, bus.ack_fault, exp_hp, !IDENT); end
    send_req(5'd3, 27'h101, 38'hB);
    tests++; if ({bus.ack_hpaddr, bus.ack_fault} !== {11'h401, 1'b0}) begin
      fails++; $display("FAIL ent_keep_hit got hp=%0h f=%b exp hp=401 f=0", bus.ack_hpaddr, bus.ack_fault); end
    send_req(5'd4, 27'h200, 38'hB);
    tests++; if ({bus.ack_hpaddr, bus.ack_ppaddr, bus.ack_fault} !== {11'h7FF, 3'd7, 1'b0}) begin
      fails++; $display("FAIL ent_new_hit got hp=%0h pp=%0d f=%b exp hp=7ff pp=7 f=0", bus.ack_hpaddr, bus.ack_ppaddr, bus.ack_fault); end
    step();
  endtask

  task automatic test_ctx_evict();
    logic [10:0] exp_hp;
    do_reset();
    for (int i = 0; i < 4; i++) send_req(5'(i), 27'h55, 38'h10 + 38'(i));
    send_fill(27'h55, 38'h10, 11'h155);
    send_req(5'd5, 27'h55, 38'h10);
    tests++; if ({bus.ack_hpaddr, bus.ack_fault, bus.snoop_valid} !== {11'h155, 1'b0, 1'b0}) begin
      fails++; $display("FAIL ctx_pre_hit got hp=%0h f=%b sv=%b exp hp=155 f=0 sv=0", bus.ack_hpaddr, bus.ack_fault, bus.snoop_valid); end
    send_req(5'd6, 27'h55, 38'h14);
    tests++; if ({bus.snoop_valid, bus.snoop_ctx, bus.snoop_sptbr} !== {1'b1, 1'b1, 38'h10}) begin
      fails++; $display("FAIL ctx_snoop0 got v=%b ctx=%b sptbr=%0h exp v=1 ctx=1 sptbr=10", bus.snoop_valid, bus.snoop_ctx, bus.snoop_sptbr); end
    tests++; if (bus.ack_fault !== !IDENT) begin fails++; $display("FAIL ctx_new_miss got=%b exp=%b", bus.ack_fault, !IDENT); end
    step();
    bus.snoop_retry = 1'b1;
    exp_hp = miss_hp(27'h55);
    send_req(5'd7, 27'h55, 38'h10);
    tests++; if ({bus.ack_rid, bus.ack_hpaddr, bus.ack_fault} !== {5'd7, exp_hp, !IDENT}) begin
      fails++; $display("FAIL ctx_old_gone got rid=%0d hp=%0h f=%b exp rid=7 hp=%0h f=%b", bus.ack_rid, bus.ack_hpaddr, bus.ack_fault, exp_hp, !IDENT); end
    bus.req_valid = 1'b1; bus.req_rid = 5'd8; bus.req_vpn = 27'h55; bus.req_sptbr = 38'h10;
    bus.fill_valid = 1'b1; bus.fill_vpn = 27'h66; bus.fill_sptbr = 38'h10; bus.fill_hpaddr = 11'h166;
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++; if ({bus.req_retry, bus.fill_retry, bus.snoop_valid, bus.snoop_ctx, bus.snoop_sptbr} !== {4'b1111, 38'h11}) begin
        fails++; $display("FAIL snoop_hold[%0d] got rr=%b fr=%b v=%b ctx=%b sptbr=%0h exp rr=1 fr=1 v=1 ctx=1 sptbr=11",
                          k, bus.req_retry, bus.fill_retry, bus.snoop_valid, bus.snoop_ctx, bus.snoop_sptbr); end
      step();
    end
    bus.snoop_retry = 1'b0; bus.req_valid = 1'b0; bus.fill_valid = 1'b0;
    step();
    tests++; if ({bus.snoop_valid, dbg_snp_state} !== {1'b0, SNP_IDLE}) begin
      fails++; $display("FAIL snoop_release got v=%b st=%0d exp v=0 st=0", bus.snoop_valid, dbg_snp_state); end
  endtask

  // Continues from test_ctx_evict: slots {14,10,12,13}, slot pointer at 2.
  task automatic test_slot_wrap();
    send_req(5'd9, 27'h1, 38'h20);
    tests++; if (bus.snoop_sptbr !== 38'h12) begin fails++; $display("FAIL wrap_snoop2 got=%0h exp=12", bus.snoop_sptbr); end
    send_req(5'd10, 27'h1, 38'h21);
    tests++; if (bus.snoop_sptbr !== 38'h13) begin fails++; $display("FAIL wrap_snoop3 got=%0h exp=13", bus.snoop_sptbr); end
    send_req(5'd11, 27'h1, 38'h22);
    tests++; if ({bus.snoop_valid, bus.snoop_sptbr} !== {1'b1, 38'h14}) begin
      fails++; $display("FAIL wrap_snoop0 got v=%b sptbr=%0h exp v=1 sptbr=14", bus.snoop_valid, bus.snoop_sptbr); end
    step();
  endtask

  task automatic test_same_cycle();
    logic [10:0] exp_hp;
    do_reset();
    send_req(5'd1, 27'h5, 38'hC);
    step();
    bus.req_valid = 1'b1; bus.req_rid = 5'd9; bus.req_vpn = 27'h77; bus.req_sptbr = 38'hC;
    bus.fill_valid = 1'b1; bus.fill_vpn = 27'h77; bus.fill_sptbr = 38'hC; bus.fill_hpaddr = 11'h3C3;
    #1;
    tests++; if ({bus.req_retry, bus.fill_retry} !== 2'b00) begin fails++; $display("FAIL same_accept got=%b exp=00", {bus.req_retry, bus.fill_retry}); end
    step();
    bus.req_valid = 1'b0; bus.fill_valid = 1'b0;
    exp_hp = miss_hp(27'h77);
    tests++; if ({bus.ack_rid, bus.ack_hpaddr, bus.ack_fault} !== {5'd9, exp_hp, !IDENT}) begin
      fails++; $display("FAIL same_miss got rid=%0d hp=%0h f=%b exp rid=9 hp=%0h f=%b", bus.ack_rid, bus.ack_hpaddr, bus.ack_fault, exp_hp, !IDENT); end
    send_req(5'd10, 27'h77, 38'hC);
    tests++; if ({bus.ack_rid, bus.ack_hpaddr, bus.ack_ppaddr, bus.ack_fault} !== {5'd10, 11'h3C3, 3'd3, 1'b0}) begin
      fails++; $display("FAIL same_next_hit got rid=%0d hp=%0h pp=%0d f=%b exp rid=10 hp=3c3 pp=3 f=0",
                        bus.ack_rid, bus.ack_hpaddr, bus.ack_ppaddr, bus.ack_fault); end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) send_req(5'(i), 27'h1, 38'h30 + 38'(i));
    step();
    bus.ack_retry = 1'b1; bus.snoop_retry = 1'b1;
    send_req(5'd4, 27'h1, 38'h34);
    tests++; if ({bus.ack_valid, bus.snoop_valid} !== 2'b11) begin fails++; $display("FAIL mid_pending got=%b exp=11", {bus.ack_valid, bus.snoop_valid}); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++; if ({bus.ack_valid, bus.snoop_valid, bus.ack_rid, bus.snoop_sptbr} !== 45'h0) begin
      fails++; $display("FAIL mid_reset_clear got av=%b sv=%b rid=%0d sptbr=%0h exp all 0", bus.ack_valid, bus.snoop_valid, bus.ack_rid, bus.snoop_sptbr); end
    tests++; if (dbg_snp_state !== SNP_IDLE) begin fails++; $display("FAIL mid_reset_state got=%0d exp=0", dbg_snp_state); end
    bus.ack_retry = 1'b0; bus.snoop_retry = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_miss();
    test_fill_hit();
    test_entry_evict();
    test_ctx_evict();
    test_slot_wrap();
    test_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
